// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Purpose  : Transmit half of a UART. A programmable baud tick generator, a
//            small circular write FIFO and a serializer FSM send 8N1 frames
//            at 16x oversampling: start bit 0, DBIT data bits LSB first,
//            stop bit 1. Queued bytes are sent back-to-back.
// Ports    : clk      - system clock
//            reset    - synchronous, active-high reset
//            dvsr     - baud divisor, one tick every dvsr+1 clocks
//            wr_uart  - one-cycle write strobe per byte
//            w_data   - byte to enqueue
//            tx       - serial output, idle high
//            tx_full  - FIFO full
// Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           dvsr,
    input  logic                  wr_uart,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  tx,
    output logic                  tx_full
);

    localparam int c_depth = 2 ** ADDR_WIDTH;
    localparam int c_nw    = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [c_nw-1:0] c_n_last  = c_nw'(DBIT - 1);
    localparam logic [3:0]      c_s_last  = 4'd15;
    localparam logic [3:0]      c_sb_last = 4'(SB_TICK - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    // ------------------------------------------------------------------
    // Baud tick generator (free running, never restarted by a frame)
    // ------------------------------------------------------------------
    logic [10:0] r_baud_cnt;
    logic        w_tick;

    assign w_tick = (r_baud_cnt >= dvsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud_cnt <= 11'd0;
        end else if (w_tick) begin
            r_baud_cnt <= 11'd0;
        end else begin
            r_baud_cnt <= r_baud_cnt + 11'd1;
        end
    end

    // ------------------------------------------------------------------
    // Write FIFO. The head entry is only popped once its frame has left
    // the wire, so a frame in flight still occupies a slot.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [c_depth];
    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic                  r_full;
    logic                  r_empty;
    logic [ADDR_WIDTH-1:0] w_wptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rptr_nxt;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_tx_done_tick;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_wr_en    = wr_uart & ~r_full;
    assign w_rd_en    = w_tx_done_tick & ~r_empty;
    assign w_wptr_nxt = r_wptr + ADDR_WIDTH'(1);
    assign w_rptr_nxt = r_rptr + ADDR_WIDTH'(1);
    assign w_head     = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            case ({w_wr_en, w_rd_en})
                2'b10: begin
                    r_wptr  <= w_wptr_nxt;
                    r_empty <= 1'b0;
                    r_full  <= (w_wptr_nxt == r_rptr);
                end
                2'b01: begin
                    r_rptr  <= w_rptr_nxt;
                    r_full  <= 1'b0;
                    r_empty <= (w_rptr_nxt == r_wptr);
                end
                2'b11: begin
                    // occupancy unchanged, flags hold
                    r_wptr <= w_wptr_nxt;
                    r_rptr <= w_rptr_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    assign tx_full = r_full;

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [3:0]      r_s;
    logic [c_nw-1:0] r_n;
    logic [DBIT-1:0] r_b;
    logic            r_tx;

    logic [1:0]      w_state_nxt;
    logic [3:0]      w_s_nxt;
    logic [c_nw-1:0] w_n_nxt;
    logic [DBIT-1:0] w_b_nxt;
    logic            w_tx_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_s     <= 4'd0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_s     <= w_s_nxt;
            r_n     <= w_n_nxt;
            r_b     <= w_b_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_s_nxt        = r_s;
        w_n_nxt        = r_n;
        w_b_nxt        = r_b;
        w_tx_nxt       = r_tx;
        w_tx_done_tick = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_tx_nxt = 1'b1;
                if (!r_empty) begin
                    w_b_nxt     = w_head;
                    w_s_nxt     = 4'd0;
                    w_state_nxt = c_st_start;
                end
            end
            c_st_start: begin
                w_tx_nxt = 1'b0;
                if (w_tick) begin
                    if (r_s == c_s_last) begin
                        w_s_nxt     = 4'd0;
                        w_n_nxt     = '0;
                        w_state_nxt = c_st_data;
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            c_st_data: begin
                w_tx_nxt = r_b[0];
                if (w_tick) begin
                    if (r_s == c_s_last) begin
                        w_s_nxt = 4'd0;
                        w_b_nxt = r_b >> 1;
                        if (r_n == c_n_last) begin
                            w_state_nxt = c_st_stop;
                        end else begin
                            w_n_nxt = r_n + c_nw'(1);
                        end
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            c_st_stop: begin
                w_tx_nxt = 1'b1;
                if (w_tick) begin
                    if (r_s == c_sb_last) begin
                        w_tx_done_tick = 1'b1;
                        w_state_nxt    = c_st_idle;
                    end else begin
                        w_s_nxt = r_s + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Registered output keeps the line glitch-free
    assign tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter
// Purpose  : Self-checking bench for uart_transmitter. Stimulus pushes the
//            bytes it expects on the wire into a queue; a line monitor
//            decodes frames from tx and compares them against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [10:0] dvsr    = 11'd3;
    logic        wr_uart = 1'b0;
    logic [7:0]  w_data  = 8'h00;
    logic        tx;
    logic        tx_full;

    always #5 clk = ~clk;

    uart_transmitter #(
        .DBIT       (8),
        .SB_TICK    (16),
        .DATA_WIDTH (8),
        .ADDR_WIDTH (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .dvsr    (dvsr),
        .wr_uart (wr_uart),
        .w_data  (w_data),
        .tx      (tx),
        .tx_full (tx_full)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] b4 [4] = '{8'h7E, 8'hFF, 8'h55, 8'hD7};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Line monitor: samples each bit at its midpoint, relative to the
    // first low sample of the start bit.
    // ------------------------------------------------------------------
    logic       mon_busy = 1'b0;
    int         mon_cnt  = 0;
    int         mon_bp   = 16;
    int         mon_k    = 0;
    logic [7:0] mon_byte = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            mon_busy = 1'b0;
        end else if (!mon_busy) begin
            if (tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_cnt  = 0;
                mon_bp   = 16 * (int'(dvsr) + 1);
                mon_byte = 8'h00;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt % mon_bp == mon_bp / 2) begin
                mon_k = mon_cnt / mon_bp;
                if (mon_k == 0) begin
                    chk("start_bit", {31'd0, tx}, 32'd0);
                end else if (mon_k <= 8) begin
                    mon_byte[mon_k-1] = tx;
                end else begin
                    chk("stop_bit", {31'd0, tx}, 32'd1);
                    chk("frame_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    if (exp_q.size() != 0) begin
                        chk("frame_data", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                    end else begin
                        $display("FAIL unexpected_frame: got %0h expected none", mon_byte);
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic write_byte(input logic [7:0] d);
        @(posedge clk); #1;
        wr_uart = 1'b1;
        w_data  = d;
        exp_q.push_back(d);
        @(posedge clk); #1;
        wr_uart = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        int i = 0;
        while ((exp_q.size() != 0 || mon_busy) && i < limit) begin
            @(negedge clk);
            i++;
        end
        chk(name, {31'd0, i < limit}, 32'd1);
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
    endtask

    int lows;
    int wcnt;

    initial begin
        // Reset / idle
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_tx_full", {31'd0, tx_full}, 32'd0);
        count_low(200, lows);
        chk("idle_no_activity", lows, 32'd0);
        chk("idle_tx_full", {31'd0, tx_full}, 32'd0);

        // Single byte with write-to-start-bit latency
        write_byte(8'h7E);
        @(negedge clk);
        chk("lat_after_write", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("lat_fsm_leaves_idle", {31'd0, tx}, 32'd1);
        @(negedge clk);
        chk("lat_start_falls", {31'd0, tx}, 32'd0);
        drain("drain_single", 2000);
        repeat (64) @(negedge clk);

        // Four back-to-back bytes, fifth write while full
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            wr_uart = 1'b1;
            w_data  = b4[i];
            exp_q.push_back(b4[i]);
        end
        @(posedge clk); #1;
        w_data = 8'h00;
        @(negedge clk);
        chk("full_after_4", {31'd0, tx_full}, 32'd1);
        @(posedge clk); #1;
        wr_uart = 1'b0;
        @(negedge clk);
        chk("full_after_drop", {31'd0, tx_full}, 32'd1);
        wcnt = 0;
        while (tx_full && wcnt < 2000) begin
            @(negedge clk);
            wcnt++;
        end
        chk("full_drop_timeout", {31'd0, wcnt < 2000}, 32'd1);
        chk("full_drop_after_frame1", exp_q.size(), 32'd3);
        drain("drain_four", 4000);
        count_low(1400, lows);
        chk("no_extra_frame", lows, 32'd0);

        // Divisor 0: tick every clock
        @(posedge clk); #1;
        dvsr = 11'd0;
        write_byte(8'hA5);
        drain("drain_dvsr0", 400);
        repeat (32) @(negedge clk);

        // Mid-frame reset during data bit 3
        @(posedge clk); #1;
        dvsr = 11'd3;
        write_byte(8'hC3);
        write_byte(8'h81);
        wcnt = 0;
        while (tx !== 1'b0 && wcnt < 200) begin
            @(negedge clk);
            wcnt++;
        end
        chk("midreset_start_seen", {31'd0, wcnt < 200}, 32'd1);
        repeat (4 * 64 + 32) @(negedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("tx_low_before_reset", {31'd0, tx}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_tx", {31'd0, tx}, 32'd1);
        chk("midreset_tx_full", {31'd0, tx_full}, 32'd0);
        count_low(2000, lows);
        chk("midreset_no_frames", lows, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
